// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizes for the memory port arbiter.
//   ARB_AW / ARB_DW : address / data widths (ISIZE / DSIZE of the core)
//   ARB_MAX_WAIT    : IF losses tolerated before IF is forced to win
//   ARB_CW          : starvation counter width (2**CW > MAX_WAIT)
//   owner_e         : which requester owns the read data returning next cycle
package mem_port_arbiter_pkg;

    localparam int unsigned ARB_AW       = 16;
    localparam int unsigned ARB_DW       = 32;
    localparam int unsigned ARB_MAX_WAIT = 3;
    localparam int unsigned ARB_CW       = 4;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_DATA = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and memory drive for mem_port_arbiter.
//   master : requesters + memory (drive requests, addresses, write data, mem_dout)
//   slave  : the arbiter (drives grants, responses and the memory port)
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW = ARB_AW,
    parameter int unsigned DW = ARB_DW
) ();

    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_wen, mem_addr, mem_din
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_wen, mem_addr, mem_din
    );

endinterface

// File: rtl/arb_starve_ctr.sv
// Counts consecutive cycles IF requested but lost; raises force_if once the
// count reaches MAX_WAIT so the arbiter hands IF one cycle.
//   clk, rst  : clock, synchronous active-high reset
//   i_req     : IF request
//   i_gnt     : IF granted this cycle
//   force_if  : counter == MAX_WAIT (decoded from the count register)
module arb_starve_ctr #(
    parameter int unsigned MAX_WAIT = 3,
    parameter int unsigned CW       = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_gnt,
    output logic force_if
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturating increment on a lost request, clear on grant or idle.
    always_comb begin
        cnt_d = '0;
        if (i_req && !i_gnt) begin
            cnt_d = (cnt_q == CW'(MAX_WAIT)) ? cnt_q : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_if = (cnt_q == CW'(MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, 1-cycle-read-latency memory between instruction
// fetch (read-only) and data access (read/write). Data wins by default; IF is
// forced through after MAX_WAIT consecutive losses. Read data is steered back
// to the requester recorded in the owner register.
//   clk, rst : clock, synchronous active-high reset (blocks all access so the
//              memory's file load is undisturbed)
//   bus      : requester handshakes, responses and memory drive (slave side)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW       = ARB_AW,
    parameter int unsigned DW       = ARB_DW,
    parameter int unsigned MAX_WAIT = ARB_MAX_WAIT,
    parameter int unsigned CW       = ARB_CW
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    logic          force_if;
    logic          i_win;
    logic          d_win;
    owner_e        owner_q;
    owner_e        owner_d;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;

    arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT),
        .CW       (CW)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .i_req    (bus.i_req),
        .i_gnt    (i_win),
        .force_if (force_if)
    );

    // Grant decision, address mux and next owner.
    always_comb begin
        i_win   = 1'b0;
        d_win   = 1'b0;
        owner_d = OWNER_NONE;
        addr_d  = rst ? '0 : addr_q;
        if (!rst) begin
            if (bus.i_req && (force_if || !bus.d_req)) begin
                i_win = 1'b1;
            end else if (bus.d_req) begin
                d_win = 1'b1;
            end
        end
        if (i_win) begin
            addr_d  = bus.i_addr;
            owner_d = OWNER_IF;
        end else if (d_win) begin
            addr_d = bus.d_addr;
            if (!bus.d_we) begin
                owner_d = OWNER_DATA;
            end
        end
    end

    // Owner of the next cycle's read data; address held across idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWNER_NONE;
            addr_q  <= '0;
        end else begin
            owner_q <= owner_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.i_gnt    = i_win;
    assign bus.d_gnt    = d_win;
    assign bus.mem_wen  = d_win & bus.d_we;
    assign bus.mem_addr = addr_d;
    assign bus.mem_din  = rst ? '0 : bus.d_wdata;

    // Reset kills an in-flight response in the same cycle.
    assign bus.i_rvalid = (owner_q == OWNER_IF)   && !rst;
    assign bus.d_rvalid = (owner_q == OWNER_DATA) && !rst;
    assign bus.i_rdata  = bus.mem_dout;
    assign bus.d_rdata  = bus.mem_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle-latency
// memory. Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    logic [DW-1:0] mem [256];

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .MAX_WAIT (3),
        .CW       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: preloaded while in reset (file load), write at edge, 1-cycle read.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[8'h04] <= 32'hDEAD_BEEF;
            mem[8'h08] <= 32'hCAFE_F00D;
            mem[8'h20] <= 32'hA5A5_0001;
        end else if (bus.mem_wen) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_din;
        end
        bus.mem_dout <= mem[bus.mem_addr[7:0]];
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus.i_req    = 1'b1;
        bus.i_addr   = 16'h0004;
        bus.d_req    = 1'b1;
        bus.d_we     = 1'b1;
        bus.d_addr   = 16'h0010;
        bus.d_wdata  = 32'h1111_2222;

        // 1: reset blocks everything
        for (int c = 0; c < 3; c++) begin
            next_cycle(); #1;
            check("rst_i_gnt",    32'(bus.i_gnt),    32'd0);
            check("rst_d_gnt",    32'(bus.d_gnt),    32'd0);
            check("rst_i_rvalid", 32'(bus.i_rvalid), 32'd0);
            check("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
            check("rst_mem_wen",  32'(bus.mem_wen),  32'd0);
            check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
            check("rst_mem_din",  32'(bus.mem_din),  32'd0);
        end

        // 2: IF read of addr 4, first cycle out of reset
        next_cycle();
        rst = 1'b0; bus.d_req = 1'b0; bus.i_req = 1'b1; bus.i_addr = 16'h0004;
        #1;
        check("if_gnt",      32'(bus.i_gnt),    32'd1);
        check("if_d_gnt",    32'(bus.d_gnt),    32'd0);
        check("if_mem_addr", 32'(bus.mem_addr), 32'h0004);
        check("if_mem_wen",  32'(bus.mem_wen),  32'd0);
        next_cycle();
        bus.i_req = 1'b0;
        #1;
        check("if_rvalid",   32'(bus.i_rvalid), 32'd1);
        check("if_rdata",    bus.i_rdata,       32'hDEAD_BEEF);
        check("if_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        check("idle_addr",   32'(bus.mem_addr), 32'h0004);
        next_cycle(); #1;
        check("if_rvalid_off", 32'(bus.i_rvalid), 32'd0);

        // 3: write 0x10 then read it back
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0010; bus.d_wdata = 32'h1234_5678;
        #1;
        check("wr_gnt",      32'(bus.d_gnt),    32'd1);
        check("wr_mem_wen",  32'(bus.mem_wen),  32'd1);
        check("wr_mem_addr", 32'(bus.mem_addr), 32'h0010);
        check("wr_mem_din",  bus.mem_din,       32'h1234_5678);
        next_cycle();
        bus.d_we = 1'b0;
        #1;
        check("rd_gnt",       32'(bus.d_gnt),    32'd1);
        check("rd_mem_wen",   32'(bus.mem_wen),  32'd0);
        check("wr_no_rvalid", 32'(bus.d_rvalid), 32'd0);
        next_cycle();
        bus.d_req = 1'b0;
        #1;
        check("rd_rvalid",   32'(bus.d_rvalid), 32'd1);
        check("rd_rdata",    bus.d_rdata,       32'h1234_5678);
        check("rd_i_rvalid", 32'(bus.i_rvalid), 32'd0);

        // 4: both requesting continuously -> D D D I repeating
        next_cycle();
        bus.i_req = 1'b1; bus.i_addr = 16'h0008;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0020;
        for (int k = 0; k < 8; k++) begin
            logic exp_ig;
            logic exp_iv;
            logic exp_dv;
            if (k > 0) next_cycle();
            #1;
            exp_ig = (k % 4 == 3);
            exp_iv = (k > 0) && ((k - 1) % 4 == 3);
            exp_dv = (k > 0) && !exp_iv;
            check("starve_i_gnt",    32'(bus.i_gnt),    32'(exp_ig));
            check("starve_d_gnt",    32'(bus.d_gnt),    32'(!exp_ig));
            check("starve_i_rvalid", 32'(bus.i_rvalid), 32'(exp_iv));
            check("starve_d_rvalid", 32'(bus.d_rvalid), 32'(exp_dv));
            if (exp_iv) check("starve_i_rdata", bus.i_rdata, 32'hCAFE_F00D);
            if (exp_dv) check("starve_d_rdata", bus.d_rdata, 32'hA5A5_0001);
        end
        // Requests dropped with the IF response outstanding
        next_cycle();
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        #1;
        check("drop_i_rvalid", 32'(bus.i_rvalid), 32'd1);
        check("drop_i_rdata",  bus.i_rdata,       32'hCAFE_F00D);
        check("drop_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        check("drop_no_gnt",   32'({bus.i_gnt, bus.d_gnt}), 32'd0);

        // 5: IF grant then data read grant
        next_cycle();
        bus.i_req = 1'b1; bus.i_addr = 16'h0004;
        #1;
        check("alt_i_gnt", 32'(bus.i_gnt), 32'd1);
        next_cycle();
        bus.i_req = 1'b0; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0010;
        #1;
        check("alt_d_gnt",    32'(bus.d_gnt),    32'd1);
        check("alt_i_rvalid", 32'(bus.i_rvalid), 32'd1);
        check("alt_i_rdata",  bus.i_rdata,       32'hDEAD_BEEF);
        check("alt_d_rv0",    32'(bus.d_rvalid), 32'd0);
        next_cycle();
        bus.d_req = 1'b0;
        #1;
        check("alt_d_rvalid", 32'(bus.d_rvalid), 32'd1);
        check("alt_d_rdata",  bus.d_rdata,       32'h1234_5678);
        check("alt_i_rv0",    32'(bus.i_rvalid), 32'd0);

        // 6: reset right after an IF grant cancels the response
        next_cycle();
        bus.i_req = 1'b1; bus.i_addr = 16'h0004;
        #1;
        check("rstx_i_gnt", 32'(bus.i_gnt), 32'd1);
        next_cycle();
        rst = 1'b1;
        #1;
        check("rstx_i_rvalid", 32'(bus.i_rvalid), 32'd0);
        check("rstx_i_gnt0",   32'(bus.i_gnt),    32'd0);
        check("rstx_addr",     32'(bus.mem_addr), 32'd0);
        for (int c = 0; c < 2; c++) begin
            next_cycle(); #1;
            check("rstx_hold_rvalid", 32'(bus.i_rvalid), 32'd0);
        end
        next_cycle();
        rst = 1'b0; bus.i_req = 1'b0;
        #1;
        check("post_i_rvalid", 32'(bus.i_rvalid), 32'd0);
        check("post_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        check("post_mem_addr", 32'(bus.mem_addr), 32'd0);
        next_cycle(); #1;
        check("post2_i_rvalid", 32'(bus.i_rvalid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port, one-cycle-read-latency `memory` block between two requesters:
  - instruction fetch (IF), read-only;
  - data access (MEM stage), read/write.
- Makes the decision each cycle, drives the memory's wen/addr/data_in, and routes the registered read data back to the requester that owns it.
- Sits between the 4-stage pipeline and a unified instruction/data memory. It also protects the memory's file-load window during reset.

Parameters:
- AW, 16, address width; matches `ISIZE.
- DW, 32, data width; matches `DSIZE.
- MAX_WAIT, 3, consecutive IF losses tolerated before IF is forced to win one cycle (1..15).
- CW, 4, starvation counter width; must satisfy 2^CW > MAX_WAIT.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  IF read request; held until granted.
- i_addr  in  AW  IF read address.
- i_gnt  out  1  IF request accepted this cycle (combinational).
- i_rvalid  out  1  i_rdata valid (registered, 1 cycle after i_gnt).
- i_rdata  out  DW  IF read data.
- d_req  in  1  data request; held until granted.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_gnt  out  1  data request accepted this cycle (combinational).
- d_rvalid  out  1  d_rdata valid (registered, reads only).
- d_rdata  out  DW  data read data.
- mem_wen  out  1  to memory wen.
- mem_addr  out  AW  to memory addr.
- mem_din  out  DW  to memory data_in.
- mem_dout  in  DW  from memory data_out; valid the cycle after the address is presented.

Behaviour:
- Reset (rst=1):
  - i_gnt = d_gnt = 0, i_rvalid = d_rvalid = 0, mem_wen = 0.
  - mem_addr = 0, mem_din = 0.
  - starve_cnt = 0, owner = NONE.
  - Requests are ignored, so the memory's file load is never disturbed.
- Reset asserted mid-transaction: any pending rvalid is cancelled in that same cycle. It never appears after reset.
- Arbitration (combinational on current requests and the force flag):
  - Default: fixed priority, data over IF.
  - force = (starve_cnt == MAX_WAIT). When force=1 and i_req=1, IF wins even if d_req=1.
  - Exactly one grant per cycle at most; no grant when there is no request.
- Memory drive:
  - The winner's address goes to mem_addr.
  - mem_wen = d_gnt & d_we; mem_din = d_wdata.
  - With no winner: mem_wen = 0 and mem_addr holds its last value (registered copy).
- Owner register (states NONE / IF / DATA), updated at posedge:
  - owner <= IF on i_gnt.
  - owner <= DATA on d_gnt & !d_we.
  - Otherwise owner <= NONE.
  - A write never produces rvalid.
- Response, one cycle after grant:
  - i_rvalid = (owner == IF); d_rvalid = (owner == DATA).
  - Both rdata outputs are driven from mem_dout. They are don't-care when their rvalid is 0.
- Starvation counter:
  - i_req & !i_gnt → increment, saturating at MAX_WAIT.
  - i_gnt or !i_req → 0.
- Back-to-back grants to either requester are allowed every cycle. Throughput is 1 access per cycle.
- Write then read of the same address on consecutive cycles: the read returns the new data, because the memory write completes at the grant edge.
- Both requesters dropping their requests while a response is outstanding: the response is still delivered the next cycle.

Decomposition:
- Shared package/defines: AW and DW reuse `ISIZE/`DSIZE; an owner enum (NONE=0, IF=1, DATA=2).
- One natural sub-module: `arb_starve_ctr`, the saturating counter plus force-flag generation.
- Everything else stays in the top module.

Test Plan:
1. rst=1 for 3 cycles with i_req=d_req=1 → all grants and rvalids 0, mem_wen=0 throughout. First grant occurs in the first cycle after rst falls.
2. Only i_req, i_addr=0x0004, memory[4]=0xDEADBEEF → i_gnt same cycle; i_rvalid=1 next cycle with i_rdata=0xDEADBEEF; d_rvalid stays 0.
3. d_req write (addr 0x0010, data 0x12345678), then d_req read of 0x0010 the next cycle → d_gnt both cycles, mem_wen=1 only in the first; d_rvalid=1 in cycle 3 with 0x12345678; no rvalid for the write.
4. i_req and d_req (read) held continuously, MAX_WAIT=3 → d_gnt in cycles 0-2, i_gnt in cycle 3, then d_gnt resumes. Repeating 4-cycle pattern; starve_cnt returns to 0 after each IF grant.
5. Alternating grants: IF grant in cycle 0, data read grant in cycle 1 → i_rvalid in cycle 1, d_rvalid in cycle 2, each with the correct memory word. rvalids never both 1.
6. rst asserted the cycle after an IF grant → i_rvalid=0 in that cycle and all following reset cycles; no stale response after rst deasserts.
